// File: rtl/irq_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : irq_ctrl_pkg
// Brief    : Shared types and constants for the CP0 interrupt request path.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_REQ     = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_t;

    localparam int         c_NSRC_DEFAULT    = 8;
    localparam int         c_CAUSE_W         = 3;
    localparam logic [4:0] c_CP0_PENDING_IDX = 5'd13;
    localparam logic [4:0] c_CP0_MASK_IDX    = 5'd12;

    // Lowest set bit index; the scan runs downward so the last hit is the lowest.
    function automatic logic [2:0] irq_lowest(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/irq_timer.sv
//------------------------------------------------------------------------------
// Module   : irq_timer
// Brief    : Periodic down counter; pulses tick once per period, period 0 = off.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module irq_timer #(
    parameter int TIMER_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               timer_we,
    input  logic [TIMER_W-1:0] timer_wdata,
    output logic               tick
);

    logic [TIMER_W-1:0] r_period;
    logic [TIMER_W-1:0] r_count;
    logic               w_enabled;

    assign w_enabled = (r_period != '0);
    assign tick      = w_enabled && (r_count == TIMER_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_period <= '0;
            r_count  <= '0;
        end else if (timer_we) begin
            r_period <= timer_wdata;
            r_count  <= timer_wdata;
        end else if (w_enabled) begin
            if (r_count == TIMER_W'(1)) begin
                r_count <= r_period;
            end else if (r_count != '0) begin
                r_count <= r_count - TIMER_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/irq_ctrl.sv
//------------------------------------------------------------------------------
// Module   : irq_ctrl
// Brief    : Sync/edge-detect/mask/prioritise device lines into one CP0 request.
//            Optional IRQ_TIMER_EN replaces source 0 with an internal timer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NSRC    = c_NSRC_DEFAULT,
    parameter int TIMER_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NSRC-1:0]    src,
    input  logic               mask_we,
    input  logic [NSRC-1:0]    mask_wdata,
    input  logic               ir_ack,
    input  logic               eret,
    output logic               ir_out,
    output logic [2:0]         ir_cause,
    output logic [NSRC-1:0]    pending,
`ifdef IRQ_TIMER_EN
    input  logic               timer_we,
    input  logic [TIMER_W-1:0] timer_wdata,
`endif
    output logic               in_service
);

    logic [NSRC-1:0] r_s1;
    logic [NSRC-1:0] r_s2;
    logic [NSRC-1:0] r_prev;
    logic [NSRC-1:0] r_pending;
    logic [NSRC-1:0] r_mask;
    logic [NSRC-1:0] w_edge;
    logic [7:0]      w_req8;
    logic            w_ack_take;
    irq_state_t      r_state;
    irq_state_t      w_state_nxt;
    logic [2:0]      r_cause;
    logic [2:0]      w_cause_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_prev <= '0;
        end else begin
            r_s1   <= src;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

`ifdef IRQ_TIMER_EN
    logic w_tick;

    irq_timer #(
        .TIMER_W     (TIMER_W)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .timer_we    (timer_we),
        .timer_wdata (timer_wdata),
        .tick        (w_tick)
    );

    // Bit 0 comes straight from the timer; the synchronised src[0] is discarded.
    assign w_edge = ((r_s2 & ~r_prev) & ~NSRC'(1)) | NSRC'(w_tick);
`else
    assign w_edge = r_s2 & ~r_prev;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask <= '1;
        end else if (mask_we) begin
            r_mask <= mask_wdata;
        end
    end

    assign w_ack_take = (r_state == IRQ_REQ) && ir_ack;

    // A fresh edge outranks the acknowledge clear so no event is lost.
    for (genvar i = 0; i < NSRC; i++) begin : g_pending
        always_ff @(posedge clk) begin
            if (rst) begin
                r_pending[i] <= 1'b0;
            end else if (w_edge[i]) begin
                r_pending[i] <= 1'b1;
            end else if (w_ack_take && (r_cause == 3'(i))) begin
                r_pending[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        w_req8            = '0;
        w_req8[NSRC-1:0]  = r_pending & r_mask;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        case (r_state)
            IRQ_IDLE: begin
                if (w_req8 != 8'd0) begin
                    w_cause_nxt = irq_lowest(w_req8);
                    w_state_nxt = IRQ_REQ;
                end
            end
            IRQ_REQ: begin
                if (ir_ack) w_state_nxt = IRQ_SERVICE;
            end
            IRQ_SERVICE: begin
                if (eret) w_state_nxt = IRQ_IDLE;
            end
            default: w_state_nxt = IRQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IRQ_IDLE;
            r_cause <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cause <= w_cause_nxt;
        end
    end

    assign ir_out     = (r_state == IRQ_REQ);
    assign in_service = (r_state == IRQ_SERVICE);
    assign ir_cause   = r_cause;
    assign pending    = r_pending;

endmodule

`default_nettype wire
